// File: rtl/i2c_pkg.sv
// i2c_pkg: shared command codes, FSM states and quarter indices for the I2C byte engine
package i2c_pkg;
  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;
  typedef enum logic [2:0] {S_IDLE, S_START, S_STOP, S_WRITE, S_READ} state_t;
  function automatic state_t to_state(input logic [1:0] c);
    return (c == CMD_START) ? S_START : (c == CMD_STOP) ? S_STOP : (c == CMD_WRITE) ? S_WRITE : S_READ;
  endfunction
endpackage

// File: rtl/i2c_sync.sv
// i2c_sync: two-flop synchronizer for an asynchronous pad input, resetting to the released level
module i2c_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  // shift the pad level through two flops
  always_ff @(posedge clk)
    if (!rst_n) {q, meta} <= 2'b11;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/i2c_byte_ctrl.sv
// i2c_byte_ctrl: byte-level I2C master stepping SCL/SDA one quarter period per I2C_CLK tick
module i2c_byte_ctrl
  import i2c_pkg::*;
(
  input  logic       PLL_CLK,
  input  logic       RESETn,
  input  logic       I2C_CLK,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD,
  input  logic [7:0] TX_DATA,
  input  logic       TX_ACK,
  output logic [7:0] RX_DATA,
  output logic       RX_ACK,
  output logic       BUSY,
  output logic       DONE,
  input  logic       SDA_I,
  output logic       SCL_OEN,
  output logic       SDA_OEN
);
  state_t     state, state_n;
  logic [1:0] q, q_n;
  logic [3:0] bit_cnt, bit_n;
  logic [7:0] shreg, shreg_n, rx_n;
  logic       ack, ack_n, scl_n, sda_n, rx_ack_n, busy_n, done_n, ready_n;
  logic       sda_s, last;

  i2c_sync u_sync (.clk(PLL_CLK), .rst_n(RESETn), .d(SDA_I), .q(sda_s));

  // state, counters, shift register and registered bus outputs
  always_ff @(posedge PLL_CLK)
    if (!RESETn) begin
      state     <= S_IDLE;
      q         <= Q0;
      bit_cnt   <= '0;
      shreg     <= '0;
      ack       <= 1'b1;
      SCL_OEN   <= 1'b1;
      SDA_OEN   <= 1'b1;
      RX_DATA   <= '0;
      RX_ACK    <= 1'b1;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      CMD_READY <= 1'b1;
    end else begin
      state     <= state_n;
      q         <= q_n;
      bit_cnt   <= bit_n;
      shreg     <= shreg_n;
      ack       <= ack_n;
      SCL_OEN   <= scl_n;
      SDA_OEN   <= sda_n;
      RX_DATA   <= rx_n;
      RX_ACK    <= rx_ack_n;
      BUSY      <= busy_n;
      DONE      <= done_n;
      CMD_READY <= ready_n;
    end

  // accept commands in IDLE, otherwise apply quarter q levels on each tick
  always_comb begin
    state_n  = state;
    q_n      = q;
    bit_n    = bit_cnt;
    shreg_n  = shreg;
    ack_n    = ack;
    scl_n    = SCL_OEN;
    sda_n    = SDA_OEN;
    rx_n     = RX_DATA;
    rx_ack_n = RX_ACK;
    busy_n   = BUSY;
    ready_n  = CMD_READY;
    done_n   = 1'b0;
    last     = (state == S_START) || (state == S_STOP) || bit_cnt[3];
    if (state == S_IDLE) begin
      if (CMD_VALID) begin
        state_n = to_state(CMD);
        shreg_n = TX_DATA;
        ack_n   = TX_ACK;
        q_n     = Q0;
        bit_n   = '0;
        busy_n  = 1'b1;
        ready_n = 1'b0;
      end
    end else if (I2C_CLK) begin
      q_n   = q + 2'd1;
      scl_n = (state == S_START) ? ((q == Q0) ? SCL_OEN : (q != Q3)) :
              (state == S_STOP)  ? (q != Q0) : ((q == Q1) || (q == Q2));
      sda_n = (state == S_START) ? ((q == Q0) || (q == Q1)) :
              (state == S_STOP)  ? (q == Q3) :
              (state == S_WRITE) ? (bit_cnt[3] | shreg[7]) : (!bit_cnt[3] | ack);
      if (q == Q2 && state == S_WRITE && bit_cnt[3]) rx_ack_n = sda_s;
      if (q == Q2 && state == S_READ && !bit_cnt[3]) rx_n = {RX_DATA[6:0], sda_s};
      if (q == Q3 && last) begin
        state_n = S_IDLE;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        ready_n = 1'b1;
      end else if (q == Q3) begin
        bit_n   = bit_cnt + 4'd1;
        shreg_n = {shreg[6:0], 1'b0};
      end
    end
  end
endmodule

// File: doc/i2c_byte_ctrl.md
# i2c_byte_ctrl

Byte-level I2C master engine that consumes the single-cycle `I2C_CLK` tick from the I2C clock generator and executes START, STOP, WRITE-byte and READ-byte commands. It drives SCL and SDA as open-drain enables. Each tick advances the bus by one quarter of an SCL period. The block sits between the register/command front-end (upstream) and the pad open-drain buffers (downstream). It supports a single master only, with no arbitration and no clock stretching.

## Interface
Parameters: none. The SCL rate is set entirely by the tick spacing from the clock generator.

Ports, clock and reset first:
- `PLL_CLK`  in  1  system clock.
- `RESETn`  in  1  synchronous, active-low reset.
- `I2C_CLK`  in  1  one-cycle quarter-period tick from the clock generator.
- `CMD_VALID`  in  1  command request.
- `CMD_READY`  out  1  high only in IDLE; a command is accepted when `CMD_VALID && CMD_READY`.
- `CMD`  in  2  command code: 00 START, 01 STOP, 10 WRITE, 11 READ.
- `TX_DATA`  in  8  byte to send on WRITE; sampled at accept.
- `TX_ACK`  in  1  ACK bit the master drives after a READ (0 = ACK, 1 = NACK); sampled at accept.
- `RX_DATA`  out  8  byte received by the last READ.
- `RX_ACK`  out  1  ACK received after the last WRITE (0 = slave acknowledged).
- `BUSY`  out  1  command in progress.
- `DONE`  out  1  one-cycle pulse when a command completes.
- `SDA_I`  in  1  raw SDA pad input (asynchronous).
- `SCL_OEN`  out  1  0 = pull SCL low, 1 = release.
- `SDA_OEN`  out  1  0 = pull SDA low, 1 = release.

## Operation
- **Reset values:** `SCL_OEN`=1, `SDA_OEN`=1, `CMD_READY`=1, `BUSY`=0, `DONE`=0, `RX_DATA`=0x00, `RX_ACK`=1. State = IDLE, quarter counter q=0, bit counter=0.
- **States:** IDLE, START, STOP, WRITE, READ.
- **Accept:** in IDLE, a handshake latches `CMD`, `TX_DATA` and `TX_ACK` into the shift register. On the same edge: `BUSY`=1, `CMD_READY`=0, q=0.
- **Quarter stepping:** each subsequent `I2C_CLK` tick applies the levels of quarter q to the registered outputs, then increments q (mod 4).
  - Ticks in IDLE are ignored.
  - A tick in the accept cycle is ignored.
  - With no ticks, the state freezes.
- **Quarter levels per state** (q0 / q1 / q2 / q3):
  - START: SCL unchanged, SDA=1 / SCL=1, SDA=1 / SCL=1, SDA=0 / SCL=0, SDA=0. From bus-idle this is a plain START; from SCL-low it is a repeated START.
  - WRITE bit: SCL=0, SDA=bit / SCL=1 / SCL=1 / SCL=0. SDA is held for the whole bit.
  - READ bit: SDA released; SCL pattern as for WRITE.
  - STOP: SCL=0, SDA=0 / SCL=1, SDA=0 / SCL=1, SDA=0 / SCL=1, SDA=1.
- **Byte transfers:** 9 bits, MSB first, with bit counter 0..8.
  - WRITE: bits 0–7 from the shift register. Bit 8 releases SDA; the ACK is sampled into `RX_ACK`.
  - READ: bits 0–7 release SDA and shift the sampled value into `RX_DATA`. Bit 8 drives SDA=`TX_ACK`.
- **Sampling:** on the tick that applies q2 (mid SCL-high), using `SDA_I` after the 2-flop synchronizer.
- **Completion:** the tick that applies q3 of the final quarter also:
  - sets `DONE`=1 for one cycle,
  - sets `BUSY`=0 and `CMD_READY`=1,
  - returns the state to IDLE.
  - The bus is left at the q3 levels: SCL low after START/WRITE/READ; both lines released after STOP.
- **`CMD_VALID` while busy:** ignored, and must not corrupt the latched command.
- **Reset mid-operation:** both lines are released on the next edge and the state returns to IDLE. Software then issues STOP to recover the slave.

## Timing
- All outputs are registered and change only on `PLL_CLK` rising edges.
- Latency from accept:
  - START or STOP: DONE on the 4th tick.
  - WRITE or READ: DONE on the 36th tick.
- With a tick every N+1 clocks: SCL period = 4(N+1) clocks; SCL high for 2 quarters.
- `DONE` and `CMD_READY`=1 occur in the same cycle, so back-to-back commands are possible. A new command may be accepted on the cycle after `DONE`.
- SDA changes only while SCL is low, except at START q2 and STOP q3.
- The synchronizer adds 2 cycles of delay; this is covered by the quarter length when N ≥ 2.

## Structure
- Shared package `i2c_pkg`:
  - command code constants: START, STOP, WRITE, READ,
  - state encoding,
  - quarter indices Q0–Q3.
- Sub-module `i2c_sync`: a 2-flop synchronizer for `SDA_I`, reusable for future SCL sensing.
- Everything else lives in `i2c_byte_ctrl`: FSM, q counter, bit counter, shift register.

## Test plan
All scenarios use CLK_div_N=3 (a tick every 4 clocks) and a pull-up model on both lines.
- **START then STOP on an idle bus:** SDA falls while SCL=1 and SCL falls 1 quarter later; DONE on the 4th tick of each command; STOP ends with SDA rising while SCL=1 and both lines released.
- **WRITE 0xA5, slave model ACKs:** SDA bits 1,0,1,0,0,1,0,1 are stable through every SCL-high window; 9th bit has SDA released; RX_ACK=0; DONE at tick 36.
- **WRITE 0x00, no slave:** RX_ACK=1; BUSY=0 after DONE.
- **READ, slave drives 0x3C, TX_ACK=1:** RX_DATA=0x3C; master SDA_OEN=1 on bit 8 (NACK); then READ with TX_ACK=0 drives SDA_OEN=0 on bit 8.
- **Handshake corners:**
  - CMD_VALID held high through a WRITE: exactly one accept.
  - Tick coincident with accept: ignored.
  - I2C_CLK held 0 for 50 cycles mid-byte: outputs frozen.
  - New command accepted 1 cycle after DONE.
- **RESETn=0 after tick 10 of a WRITE:** next edge SCL_OEN=1, SDA_OEN=1, BUSY=0, CMD_READY=1, RX_ACK=1; a subsequent START completes normally.
